// File: rtl/lsu_bus.sv
// lsu_bus: memory-stage load/store unit.
//
// Takes the M-stage access request (mem_read/mem_write, mem_size, addr,
// wdata), checks alignment and size legality, and runs a single word-wide
// bus transaction with a req/ready handshake. The pipeline is held with
// `stall` until the access completes. Loads come back shifted into place
// and sign/zero extended. A REQ-cycle counter aborts a transaction that the
// bus never acknowledges.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   mem_read, mem_write  M-stage load / store request
//   mem_size             RISC-V funct3 (B, H, W, BU, HU)
//   addr, wdata          byte address and LSB-justified store data
//   rdata                aligned, extended load result (valid in DONE)
//   stall                holds the pipeline while an access is in flight
//   fault                one-cycle pulse in DONE on illegal access or timeout
//   bus_req, bus_we      bus request and direction
//   bus_addr, bus_be     word address and byte enables
//   bus_wdata            lane-replicated store data
//   bus_ready, bus_rdata bus acknowledge and read word

module lsu_bus #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] reqCount;
    logic [2:0]  sizeQ;
    logic [1:0]  offsetQ;
    logic        faultQ;
    logic [31:0] rdataQ;

    logic        acc;
    logic        illegal;
    logic [3:0]  storeBe;
    logic [31:0] storeData;

    assign acc   = mem_read | mem_write;
    assign stall = acc & (state != DONE);
    assign fault = faultQ;
    assign rdata = rdataQ;

    // Shift the addressed bytes down to bit 0 and extend to 32 bits.
    function automatic logic [31:0] alignLoad(input logic [31:0] word,
                                              input logic [2:0]  size,
                                              input logic [1:0]  offset);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (size)
            3'b000:  return {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  return {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  return {24'h0, shifted[7:0]};
            3'b101:  return {16'h0, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

    // Unsigned sizes exist only for loads; 011/110/111 are not encodings.
    always_comb begin
        illegal = 1'b0;
        if (mem_read & mem_write)
            illegal = 1'b1;
        if ((mem_size == 3'b011) || (mem_size[2:1] == 2'b11))
            illegal = 1'b1;
        if (mem_write & mem_size[2])
            illegal = 1'b1;
        if ((mem_size[1:0] == 2'b01) && addr[0])
            illegal = 1'b1;
        if ((mem_size == 3'b010) && (addr[1:0] != 2'b00))
            illegal = 1'b1;
    end

    // Store data is replicated across all lanes so the enables alone select.
    always_comb begin
        storeBe   = 4'b0000;
        storeData = 32'h0;
        case (mem_size[1:0])
            2'b00: begin
                storeBe   = 4'b0001 << addr[1:0];
                storeData = {4{wdata[7:0]}};
            end
            2'b01: begin
                storeBe   = addr[1] ? 4'b1100 : 4'b0011;
                storeData = {2{wdata[15:0]}};
            end
            2'b10: begin
                storeBe   = 4'b1111;
                storeData = wdata;
            end
            default: begin
                storeBe   = 4'b0000;
                storeData = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            reqCount  <= 16'h0;
            sizeQ     <= 3'b000;
            offsetQ   <= 2'b00;
            faultQ    <= 1'b0;
            rdataQ    <= 32'h0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    faultQ <= 1'b0;
                    rdataQ <= 32'h0;
                    if (acc) begin
                        if (illegal) begin
                            state  <= DONE;
                            faultQ <= 1'b1;
                        end else begin
                            state     <= REQ;
                            reqCount  <= 16'h0;
                            sizeQ     <= mem_size;
                            offsetQ   <= addr[1:0];
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= mem_write ? storeBe : 4'b1111;
                            bus_wdata <= mem_write ? storeData : 32'h0;
                        end
                    end
                end
                REQ: begin
                    // An acknowledge wins over a timeout in the same cycle.
                    if (bus_ready) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        faultQ  <= 1'b0;
                        rdataQ  <= bus_we ? 32'h0 : alignLoad(bus_rdata, sizeQ, offsetQ);
                    end else if (reqCount == TIMEOUT_CNT) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        faultQ  <= 1'b1;
                        rdataQ  <= 32'h0;
                    end else begin
                        reqCount <= reqCount + 16'h1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    faultQ <= 1'b0;
                    rdataQ <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
